// File: rtl/serial_word_comparator.sv
// Byte-serial magnitude comparator: words arrive LSB first and resolve through one
// eight_bit_comparator with registered cascade feedback. Optional macro: SERCMP_SIGNED_EN.

module eight_bit_comparator (
   output logic       l,
   output logic       e,
   output logic       g,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       l_in,
   input  logic       e_in,
   input  logic       g_in
);
   always_comb begin
      l = 1'b0;
      e = 1'b0;
      g = 1'b0;
      if (a < b) begin
         l = 1'b1;
      end else if (a > b) begin
         g = 1'b1;
      end else begin
         l = l_in;
         e = e_in;
         g = g_in;
      end
   end
endmodule

module serial_word_comparator #(
   parameter int NUM_BYTES = 4,
   parameter int CNT_W     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a_byte,
   input  logic [7:0] b_byte,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       lt,
   output logic       eq,
   output logic       gt,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt;
   logic             acc_l, acc_e, acc_g;
   logic             cmp_l, cmp_e, cmp_g;
   logic             nxt_l, nxt_e, nxt_g;
   logic             accept, is_last;

   assign in_ready = (state_q != HOLD);
   assign accept   = in_valid && in_ready;
   assign is_last  = (cnt == CNT_W'(NUM_BYTES - 1));

   eight_bit_comparator u_cmp (
      .l    (cmp_l),
      .e    (cmp_e),
      .g    (cmp_g),
      .a    (a_byte),
      .b    (b_byte),
      .l_in (acc_l),
      .e_in (acc_e),
      .g_in (acc_g)
   );

`ifdef SERCMP_SIGNED_EN
   // Differing sign bits on the top byte decide the result outright.
   always_comb begin
      nxt_l = cmp_l;
      nxt_e = cmp_e;
      nxt_g = cmp_g;
      if (is_last && (a_byte[7] != b_byte[7])) begin
         nxt_l = a_byte[7];
         nxt_e = 1'b0;
         nxt_g = b_byte[7];
      end
   end
`else
   assign nxt_l = cmp_l;
   assign nxt_e = cmp_e;
   assign nxt_g = cmp_g;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, ACCUM: if (accept) state_d = is_last ? HOLD : ACCUM;
            HOLD:        if (res_ready) state_d = IDLE;
            default:     state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         acc_l     <= 1'b0;
         acc_e     <= 1'b1;
         acc_g     <= 1'b0;
         res_valid <= 1'b0;
         lt        <= 1'b0;
         eq        <= 1'b0;
         gt        <= 1'b0;
         busy      <= 1'b0;
      end else if (clr || (state_q == HOLD && res_ready)) begin
         cnt       <= '0;
         acc_l     <= 1'b0;
         acc_e     <= 1'b1;
         acc_g     <= 1'b0;
         res_valid <= 1'b0;
         lt        <= 1'b0;
         eq        <= 1'b0;
         gt        <= 1'b0;
         busy      <= 1'b0;
      end else if (accept) begin
         cnt   <= cnt + 1'b1;
         acc_l <= nxt_l;
         acc_e <= nxt_e;
         acc_g <= nxt_g;
         busy  <= 1'b1;
         if (is_last) begin
            res_valid <= 1'b1;
            lt        <= nxt_l;
            eq        <= nxt_e;
            gt        <= nxt_g;
         end
      end
   end
endmodule

// File: doc/serial_word_comparator.md
Name: serial_word_comparator

Overview:
- Sequential stage that wraps one eight_bit_comparator instance and compares two multi-byte words one byte pair per cycle.
- Bytes arrive LSB first. The registered partial result is fed back into the comparator's cascade inputs (lesser/equal/greater from the lower-significance stage). Cascade is used only when the current bytes are equal.
- Sits upstream of the comparator's cascade inputs and downstream of the comparator's l/e/g outputs. Delivers a final lt/eq/gt result over a valid/ready handshake.

Parameters:
- NUM_BYTES, 4, number of byte pairs per word; legal range 1..16.
- CNT_W, 4, byte counter width; must satisfy 2^CNT_W >= NUM_BYTES.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush; aborts any word in progress.
- in_valid  input  1  byte pair a_byte/b_byte offered.
- in_ready  output  1  block accepts a byte pair this cycle.
- a_byte  input  8  current byte of word A, LSB first.
- b_byte  input  8  current byte of word B, LSB first.
- res_valid  output  1  final result available.
- res_ready  input  1  consumer takes the result.
- lt  output  1  A < B (valid while res_valid).
- eq  output  1  A == B (valid while res_valid).
- gt  output  1  A > B (valid while res_valid).
- busy  output  1  at least one byte of the current word has been accepted.

Behaviour:
- Reset: rst_n low asynchronously forces the following, effective immediately regardless of clk.
  - state = IDLE, cnt = 0.
  - Accumulator acc = {l=0, e=1, g=0}.
  - res_valid=0, lt=0, eq=0, gt=0, busy=0.
  - in_ready=1 once rst_n is high.
- Accept condition: in_valid && in_ready at a rising edge.
- Comparator update: each accepted pair is compared by eight_bit_comparator(l, e, g, a_byte, b_byte, acc.l, acc.e, acc.g). The result is registered into acc, so exactly one of acc.l/e/g is set.
- FSM:
  - IDLE: in_ready=1. On accept, go to ACCUM, cnt=1, acc updated, busy=1. If NUM_BYTES==1, go directly to HOLD instead.
  - ACCUM: in_ready=1. On accept, cnt increments and acc is updated. On the accept where cnt == NUM_BYTES-1, go to HOLD.
  - HOLD: in_ready=0, res_valid=1.
    - lt/eq/gt present the final acc and are held stable while res_ready is low.
    - On res_ready, go to IDLE: res_valid=0, acc back to equal, cnt=0, busy=0, lt/eq/gt back to 0.
- Latency: res_valid rises on the rising edge that accepts the last byte pair, i.e. it is visible in the next cycle. The minimum word period is NUM_BYTES+1 cycles.
- No overlap: a byte offered in the same cycle as the result handshake is not accepted, since in_ready=0 in HOLD.
- in_valid gaps in ACCUM: cnt and acc hold; there is no timeout.
- clr:
  - Sampled at rising edge; has priority over every handshake in that cycle.
  - Returns the block to the reset state, including dropping a pending result.
  - The byte offered in the clr cycle is not accepted.
- Outputs lt/eq/gt/res_valid/busy are registered; in_ready is decoded from the state only, with no combinational path from in_valid or res_ready.

Optional Feature:
- Macro: SERCMP_SIGNED_EN.
- Defined: the words are two's complement. On the most significant byte (cnt == NUM_BYTES-1), if a_byte[7] != b_byte[7], the result is forced regardless of the cascade:
  - lt when a_byte[7]=1.
  - gt when b_byte[7]=1.
  - Otherwise (sign bits equal) the normal unsigned byte compare with cascade applies.
- Undefined: purely unsigned comparison; no extra logic is synthesized.

Test Plan (NUM_BYTES=4 unless stated; words listed MSB..LSB, fed LSB first):
- Equal words: A=B=0x2D2D2D2D, in_valid held high, res_ready=1 -> res_valid high exactly one cycle after the 4th accept with lt=0, eq=1, gt=0. in_ready=0 for that cycle, back to 1 in the next.
- Cascade resolution:
  - A=0x00000001, B=0x00000002 -> lt=1.
  - A=0x01000000, B=0x00FFFFFF -> gt=1 (the MSB byte overrides the lower-byte cascade).
- Backpressure and gaps:
  - in_valid toggled 1,0,1,0... -> result still correct after 4 accepts.
  - Then res_ready low for 3 cycles -> res_valid, lt/eq/gt stable, in_ready=0, offered byte not consumed. Result drains on the first res_ready cycle.
- clr mid-word: clr asserted after 2 accepted bytes -> busy=0, cnt=0. A fresh 4-byte word A=0x10000000, B=0x0FFFFFFF then yields gt=1, uncontaminated by the earlier bytes.
- Async reset mid-word and in HOLD: rst_n pulsed low between clock edges -> res_valid, lt, eq, gt, busy drop to 0 immediately. After release, an A=B word gives eq=1.
- Signed vs unsigned: A=0x80000000, B=0x00000001 -> gt=1 without SERCMP_SIGNED_EN, lt=1 with it.
- Single-byte word (NUM_BYTES=1) with SERCMP_SIGNED_EN: A=0xFF, B=0x01 -> lt=1.
